// File: rtl/ft_alu_ctrl.sv
// ft_alu_ctrl: request/response controller for a dual-rail ALU. It retries when both rails report an error.
// Defining FT_ALU_CTRL_CROSSCHK_EN makes two clean rails that disagree count as a double error.
module ft_alu_ctrl #(
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    input  logic [1:0] req_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic       alu_par,
    output logic [2:0] alu_c,
    input  logic [2:0] alu_x,
    input  logic [2:0] alu_y,
    input  logic       alu_xc,
    input  logic       alu_yc,
    input  logic [1:0] alu_xe,
    input  logic [1:0] alu_ye,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_carry,
    output logic [1:0] rsp_status,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

    localparam logic [1:0] ST_X     = 2'b00;
    localparam logic [1:0] ST_Y     = 2'b01;
    localparam logic [1:0] ST_FATAL = 2'b10;
    localparam logic [1:0] ST_ILL   = 2'b11;

    state_t     r_state, w_state_nxt;
    logic       r_req_ready, w_req_ready_nxt;
    logic [2:0] r_alu_a, w_alu_a_nxt;
    logic [2:0] r_alu_b, w_alu_b_nxt;
    logic [2:0] r_alu_c, w_alu_c_nxt;
    logic       r_alu_par, w_alu_par_nxt;
    logic       r_rsp_valid, w_rsp_valid_nxt;
    logic [2:0] r_rsp_sum, w_rsp_sum_nxt;
    logic       r_rsp_carry, w_rsp_carry_nxt;
    logic [1:0] r_rsp_status, w_rsp_status_nxt;
    logic [7:0] r_err_cnt, w_err_cnt_nxt;
    logic [2:0] r_retry_cnt, w_retry_cnt_nxt;

    logic       w_accept;
    logic       w_x_ok;
    logic       w_y_ok;
    logic       w_clash;
    logic       w_x_take;
    logic       w_y_take;
    logic [7:0] w_err_inc;
    logic [2:0] w_op_c;

    assign w_accept  = r_req_ready & req_valid;
    assign w_x_ok    = alu_xe == 2'b10;
    assign w_y_ok    = alu_ye == 2'b10;
`ifdef FT_ALU_CTRL_CROSSCHK_EN
    assign w_clash   = w_x_ok & w_y_ok & ({alu_xc, alu_x} != {alu_yc, alu_y});
`else
    assign w_clash   = 1'b0;
`endif
    assign w_x_take  = w_x_ok & ~w_clash;
    assign w_y_take  = ~w_x_ok & w_y_ok;
    assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
    assign w_op_c    = (req_op == 2'b00) ? 3'b001 : (req_op == 2'b01) ? 3'b010 : 3'b100;

    always_comb begin
        w_state_nxt      = r_state;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_alu_c_nxt      = r_alu_c;
        w_alu_par_nxt    = r_alu_par;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_sum_nxt    = r_rsp_sum;
        w_rsp_carry_nxt  = r_rsp_carry;
        w_rsp_status_nxt = r_rsp_status;
        w_err_cnt_nxt    = r_err_cnt;
        w_retry_cnt_nxt  = r_retry_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && req_op == 2'b11) begin
                    w_state_nxt      = RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_sum_nxt    = 3'b000;
                    w_rsp_carry_nxt  = 1'b0;
                    w_rsp_status_nxt = ST_ILL;
                end else if (w_accept) begin
                    w_state_nxt      = DRIVE;
                    w_alu_a_nxt      = req_a;
                    w_alu_b_nxt      = req_b;
                    w_alu_c_nxt      = w_op_c;
                    w_alu_par_nxt    = ~^{req_a, req_b};
                    w_retry_cnt_nxt  = 3'd0;
                end
            end
            DRIVE: w_state_nxt = SAMPLE;
            SAMPLE: begin
                if (w_x_take) begin
                    w_state_nxt      = RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_sum_nxt    = alu_x;
                    w_rsp_carry_nxt  = alu_xc;
                    w_rsp_status_nxt = ST_X;
                end else if (w_y_take) begin
                    w_state_nxt      = RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_sum_nxt    = alu_y;
                    w_rsp_carry_nxt  = alu_yc;
                    w_rsp_status_nxt = ST_Y;
                    w_err_cnt_nxt    = w_err_inc;
                end else if (r_retry_cnt < 3'(MAX_RETRY)) begin
                    w_state_nxt      = DRIVE;
                    w_retry_cnt_nxt  = r_retry_cnt + 3'd1;
                    w_err_cnt_nxt    = w_err_inc;
                end else begin
                    // Retries exhausted: report rail X as-is so the consumer sees what the ALU produced.
                    w_state_nxt      = RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_sum_nxt    = alu_x;
                    w_rsp_carry_nxt  = alu_xc;
                    w_rsp_status_nxt = ST_FATAL;
                    w_err_cnt_nxt    = w_err_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_req_ready_nxt = w_state_nxt == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b0;
            r_alu_a      <= 3'b000;
            r_alu_b      <= 3'b000;
            r_alu_c      <= 3'b001;
            r_alu_par    <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_sum    <= 3'b000;
            r_rsp_carry  <= 1'b0;
            r_rsp_status <= 2'b00;
            r_err_cnt    <= 8'd0;
            r_retry_cnt  <= 3'd0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_alu_c      <= w_alu_c_nxt;
            r_alu_par    <= w_alu_par_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_sum    <= w_rsp_sum_nxt;
            r_rsp_carry  <= w_rsp_carry_nxt;
            r_rsp_status <= w_rsp_status_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_retry_cnt  <= w_retry_cnt_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_c      = r_alu_c;
    assign alu_par    = r_alu_par;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_sum    = r_rsp_sum;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_status = r_rsp_status;
    assign err_cnt    = r_err_cnt;
endmodule
